// File: rtl/onehot_pkg.sv
// Shared constants and types for the one-hot encoder/decoder pair.
package onehot_pkg;

    localparam int unsigned ONEHOT_N = 16;
    localparam int unsigned ONEHOT_W = 4;

    // Classification of a candidate one-hot word.
    typedef enum logic [1:0] {
        OH_OK    = 2'd0,
        OH_ZERO  = 2'd1,
        OH_MULTI = 2'd2
    } oh_class_e;

endpackage

// File: rtl/onehot_check.sv
// Combinational one-hot classifier: legal / zero / multi-hot plus lowest set bit index.
module onehot_check
    import onehot_pkg::*;
#(
    parameter int unsigned N = ONEHOT_N,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] data_i,
    output oh_class_e    class_o,
    output logic [W-1:0] index_o
);

    logic found;
    logic multi;

    // Priority scan from bit 0: first hit sets the index, any later hit marks multi-hot.
    always_comb begin
        index_o = '0;
        found   = 1'b0;
        multi   = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (data_i[i]) begin
                if (!found) begin
                    index_o = W'(i);
                    found   = 1'b1;
                end else begin
                    multi = 1'b1;
                end
            end
        end
    end

    // Map scan results onto the class encoding.
    always_comb begin
        class_o = OH_OK;
        if (!found) begin
            class_o = OH_ZERO;
        end else if (multi) begin
            class_o = OH_MULTI;
        end
    end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// One-hot to binary decoder with a single registered valid/ready stage and a saturating
// illegal-word counter. Optional build macro ONEHOT_ERR_DROP_EN: illegal words are counted
// but not forwarded, and out_err is always 0.
module onehot_decoder_pipe
    import onehot_pkg::*;
#(
    parameter int unsigned N         = ONEHOT_N,
    parameter int unsigned W         = $clog2(N),
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_index,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 err_sticky,
    input  logic                 clear_err
);

    localparam logic [ERR_CNT_W-1:0] CntMax = '1;

    oh_class_e            chk_class;
    logic [W-1:0]         chk_index;
    logic                 illegal;
    logic                 in_acc;
    logic                 out_acc;

    logic                 valid_q,  valid_d;
    logic [W-1:0]         index_q,  index_d;
    logic                 err_q,    err_d;
    logic [ERR_CNT_W-1:0] cnt_q,    cnt_d;
    logic                 sticky_q, sticky_d;

    onehot_check #(
        .N (N),
        .W (W)
    ) u_check (
        .data_i  (in_data),
        .class_o (chk_class),
        .index_o (chk_index)
    );

    assign illegal  = (chk_class != OH_OK);
    assign in_ready = !valid_q || out_ready;
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = valid_q && out_ready;

    // Output register next state: load on input accept, else drain on output accept, else hold.
    always_comb begin
        valid_d = valid_q;
        index_d = index_q;
        err_d   = err_q;
        if (in_acc) begin
`ifdef ONEHOT_ERR_DROP_EN
            if (!illegal) begin
                valid_d = 1'b1;
                index_d = chk_index;
                err_d   = 1'b0;
            end else if (out_acc) begin
                // Dropped word still frees the stage if the consumer took the old one.
                valid_d = 1'b0;
            end
`else
            valid_d = 1'b1;
            index_d = chk_index;
            err_d   = illegal;
`endif
        end else if (out_acc) begin
            valid_d = 1'b0;
        end
    end

    // Error bookkeeping: clear first, then count an illegal accept on top of it.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clear_err) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
        if (in_acc && illegal) begin
            sticky_d = 1'b1;
            if (cnt_d != CntMax) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            index_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            index_q  <= index_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_index  = index_q;
    assign out_err    = err_q;
    assign err_count  = cnt_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Directed self-checking bench for onehot_decoder_pipe (default 8-bit counter plus a 2-bit
// counter instance for saturation).
module tb_onehot_decoder_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, out_err, err_sticky, clear_err;
    logic [15:0] in_data;
    logic [3:0]  out_index;
    logic [7:0]  err_count;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err, s_err_sticky;
    logic        s_clear_err;
    logic [15:0] s_in_data;
    logic [3:0]  s_out_index;
    logic [1:0]  s_err_count;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    onehot_decoder_pipe u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_err    (out_err),
        .err_count  (err_count),
        .err_sticky (err_sticky),
        .clear_err  (clear_err)
    );

    onehot_decoder_pipe #(
        .ERR_CNT_W (2)
    ) u_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_data    (s_in_data),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_index  (s_out_index),
        .out_err    (s_out_err),
        .err_count  (s_err_count),
        .err_sticky (s_err_sticky),
        .clear_err  (s_clear_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        clear_err   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b1;
        s_clear_err = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_index", out_index, 0);
        check_eq("rst_out_err", out_err, 0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_err_sticky", err_sticky, 0);
        check_eq("rst_in_ready", in_ready, 1);

        // 1. Loopback stream 0..15 at full rate
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0001 << i;
            step();
            check_eq($sformatf("loop_valid_%0d", i), out_valid, 1);
            check_eq($sformatf("loop_index_%0d", i), out_index, i);
            check_eq($sformatf("loop_err_%0d", i), out_err, 0);
        end
        in_valid = 1'b0;
        step();
        check_eq("loop_drained", out_valid, 0);
        check_eq("loop_err_count", err_count, 0);

        // 2. Illegal words
        in_valid = 1'b1;
        in_data  = 16'h0000;
        step();
        check_eq("zero_index", out_index, 0);
        check_eq("zero_err", out_err, 1);
        check_eq("zero_valid", out_valid, 1);
        in_data = 16'h0014;
        step();
        check_eq("multi_index", out_index, 2);
        check_eq("multi_err", out_err, 1);
        check_eq("ill_err_count", err_count, 2);
        check_eq("ill_err_sticky", err_sticky, 1);
        // Illegal data without valid must not count
        in_valid = 1'b0;
        in_data  = 16'h0000;
        step();
        step();
        check_eq("novalid_err_count", err_count, 2);
        check_eq("novalid_out_valid", out_valid, 0);

        // 3. Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0100;
        step();
        check_eq("bp_index", out_index, 8);
        check_eq("bp_in_ready", in_ready, 0);
        step();
        check_eq("bp_hold_index", out_index, 8);
        check_eq("bp_hold_valid", out_valid, 1);
        in_data = 16'h8000;
        step();
        check_eq("bp_stall_index", out_index, 8);
        check_eq("bp_stall_in_ready", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_in_ready", in_ready, 1);
        step();
        check_eq("bp_next_index", out_index, 15);
        check_eq("bp_next_valid", out_valid, 1);
        in_valid = 1'b0;
        step();

        // 4. Saturation on the 2-bit counter instance
        s_in_valid = 1'b1;
        s_in_data  = 16'h0000;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_eq($sformatf("sat_count_%0d", i), s_err_count, (i < 3) ? i : 3);
        end
        s_clear_err = 1'b1;
        step();
        check_eq("sat_clr_ill_count", s_err_count, 1);
        check_eq("sat_clr_ill_sticky", s_err_sticky, 1);
        s_in_valid = 1'b0;
        step();
        check_eq("sat_clr_count", s_err_count, 0);
        check_eq("sat_clr_sticky", s_err_sticky, 0);
        s_clear_err = 1'b0;

        // 5. Reset mid-stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0002;
        step();
        check_eq("rs_pre_valid", out_valid, 1);
        check_eq("rs_pre_count", err_count, 2);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rs_out_valid", out_valid, 0);
        check_eq("rs_err_count", err_count, 0);
        check_eq("rs_err_sticky", err_sticky, 0);
        check_eq("rs_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();

        // 6. Mixed stream; illegal word is forwarded or dropped depending on build
        in_valid = 1'b1;
        in_data  = 16'h0001;
        step();
        check_eq("mix0_valid", out_valid, 1);
        check_eq("mix0_index", out_index, 0);
        in_data = 16'h0003;
        step();
`ifdef ONEHOT_ERR_DROP_EN
        check_eq("mix1_valid", out_valid, 0);
        check_eq("mix1_err", out_err, 0);
`else
        check_eq("mix1_valid", out_valid, 1);
        check_eq("mix1_index", out_index, 0);
        check_eq("mix1_err", out_err, 1);
`endif
        check_eq("mix1_in_ready", in_ready, 1);
        in_data = 16'h0004;
        step();
        check_eq("mix2_valid", out_valid, 1);
        check_eq("mix2_index", out_index, 2);
        check_eq("mix2_err", out_err, 0);
        check_eq("mix_err_count", err_count, 1);
        in_valid = 1'b0;
        step();
        check_eq("mix_drained", out_valid, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
